// File: rtl/flow_stats_counter.sv
// flow_stats_counter
//   Per-flow packet and byte statistics held in one RAM word per flow
//   ({pkts, bytes}). Every accepted rx packet adds pkt_size_i to the flow's
//   byte counter and 1 to its packet counter. A host read returns both
//   counters and, when CLEAR_ON_READ is set, zeroes them.
//
//   Three-stage read-modify-write pipeline:
//     S0  op registered, RAM read address presented
//     S1  RAM data returns, operand forwarded from S2 / last committed write
//     S2  result computed, RAM written, read results registered
//
//   Read handshake: a read is accepted on a clock edge where rd_stb_i and
//   rd_rdy_o are both high. rd_rdy_o depends only on registered state, so the
//   host may sample it any time in the cycle. rd_data_val_o pulses for one
//   cycle per accepted read; rd_data_o / rd_pkts_o hold until the next read.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-low reset
//   rx_flow_num_i         flow of the incoming packet
//   pkt_size_i            packet size in bytes
//   pkt_size_en_i         update strobe (ignored until init_done_o)
//   rd_stb_i              host read request
//   rd_flow_num_i         flow to read
//   rd_rdy_o              read can be accepted this cycle
//   rd_data_o, rd_pkts_o  byte / packet count of the last read flow
//   rd_data_val_o         read result valid pulse
//   init_done_o           memory clear sweep complete
module flow_stats_counter #(
    parameter int A_WIDTH       = 10,
    parameter int D_WIDTH       = 32,
    parameter int P_WIDTH       = 24,
    parameter int CLEAR_ON_READ = 1,
    parameter int SATURATE      = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [A_WIDTH-1:0] rx_flow_num_i,
    input  logic [15:0]        pkt_size_i,
    input  logic               pkt_size_en_i,
    input  logic               rd_stb_i,
    input  logic [A_WIDTH-1:0] rd_flow_num_i,
    output logic               rd_rdy_o,
    output logic [D_WIDTH-1:0] rd_data_o,
    output logic [P_WIDTH-1:0] rd_pkts_o,
    output logic               rd_data_val_o,
    output logic               init_done_o
);
    localparam int DEPTH = 1 << A_WIDTH;
    localparam int W     = D_WIDTH + P_WIDTH;

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] ram_q;

    logic               init_done_q, init_done_d;
    logic [A_WIDTH-1:0] init_addr_q, init_addr_d;
    logic               pend_q, pend_d;
    logic [A_WIDTH-1:0] pend_flow_q, pend_flow_d;

    logic               s0_vld_q, s0_vld_d, s0_rd_q, s0_rd_d;
    logic [A_WIDTH-1:0] s0_flow_q, s0_flow_d;
    logic [15:0]        s0_size_q, s0_size_d;
    logic               s1_vld_q, s1_rd_q;
    logic [A_WIDTH-1:0] s1_flow_q;
    logic [15:0]        s1_size_q;
    logic               s2_vld_q, s2_rd_q;
    logic [A_WIDTH-1:0] s2_flow_q;
    logic [15:0]        s2_size_q;
    logic [D_WIDTH-1:0] s2_bytes_q, s2_bytes_d;
    logic [P_WIDTH-1:0] s2_pkts_q, s2_pkts_d;

    logic               lw_vld_q;
    logic [A_WIDTH-1:0] lw_flow_q;
    logic [D_WIDTH-1:0] lw_bytes_q;
    logic [P_WIDTH-1:0] lw_pkts_q;

    logic [D_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [P_WIDTH-1:0] rd_pkts_q, rd_pkts_d;
    logic               rd_val_q, rd_val_d;

    logic               upd_ok, rd_acc;
    logic [D_WIDTH:0]   byte_sum;
    logic [P_WIDTH:0]   pkt_sum;
    logic [D_WIDTH-1:0] s2_wb;
    logic [P_WIDTH-1:0] s2_wp;
    logic               s2_we;
    logic               mem_we;
    logic [A_WIDTH-1:0] mem_waddr;
    logic [W-1:0]       mem_wdata;

    assign rd_rdy_o      = init_done_q && !pend_q;
    assign rd_data_o     = rd_data_q;
    assign rd_pkts_o     = rd_pkts_q;
    assign rd_data_val_o = rd_val_q;
    assign init_done_o   = init_done_q;

    // Issue arbitration: updates always win; a read that collides with an
    // update parks in the pending slot and issues on the next update-free cycle.
    always_comb begin
        upd_ok      = init_done_q && pkt_size_en_i;
        rd_acc      = rd_stb_i && rd_rdy_o;
        s0_vld_d    = 1'b0;
        s0_rd_d     = 1'b0;
        s0_flow_d   = rx_flow_num_i;
        s0_size_d   = pkt_size_i;
        pend_d      = pend_q;
        pend_flow_d = pend_flow_q;
        if (upd_ok) begin
            s0_vld_d = 1'b1;
            if (rd_acc) begin
                pend_d      = 1'b1;
                pend_flow_d = rd_flow_num_i;
            end
        end else if (pend_q) begin
            s0_vld_d  = 1'b1;
            s0_rd_d   = 1'b1;
            s0_flow_d = pend_flow_q;
            pend_d    = 1'b0;
        end else if (rd_acc) begin
            s0_vld_d  = 1'b1;
            s0_rd_d   = 1'b1;
            s0_flow_d = rd_flow_num_i;
        end
    end

    // Clear sweep: one address per cycle, done flag set with the last write.
    always_comb begin
        init_addr_d = init_addr_q;
        init_done_d = init_done_q;
        if (!init_done_q) begin
            init_addr_d = init_addr_q + 1'b1;
            if (init_addr_q == {A_WIDTH{1'b1}}) begin
                init_done_d = 1'b1;
            end
        end
    end

    // S2 compute. Each counter saturates (or wraps) independently.
    always_comb begin
        byte_sum = {1'b0, s2_bytes_q} + (D_WIDTH + 1)'(s2_size_q);
        pkt_sum  = {1'b0, s2_pkts_q} + (P_WIDTH + 1)'(1);
        s2_wb    = byte_sum[D_WIDTH-1:0];
        s2_wp    = pkt_sum[P_WIDTH-1:0];
        if (SATURATE != 0 && byte_sum[D_WIDTH]) s2_wb = '1;
        if (SATURATE != 0 && pkt_sum[P_WIDTH])  s2_wp = '1;
        if (s2_rd_q) begin
            s2_wb = '0;
            s2_wp = '0;
        end
        s2_we = s2_vld_q && (!s2_rd_q || CLEAR_ON_READ != 0);
    end

    // S1 operand: the RAM word is stale if S2 is about to write the same flow
    // or if the same flow was written on the edge that captured ram_q.
    always_comb begin
        s2_bytes_d = ram_q[D_WIDTH-1:0];
        s2_pkts_d  = ram_q[W-1:D_WIDTH];
        if (s2_we && s2_flow_q == s1_flow_q) begin
            s2_bytes_d = s2_wb;
            s2_pkts_d  = s2_wp;
        end else if (lw_vld_q && lw_flow_q == s1_flow_q) begin
            s2_bytes_d = lw_bytes_q;
            s2_pkts_d  = lw_pkts_q;
        end
    end

    always_comb begin
        rd_val_d  = s2_vld_q && s2_rd_q;
        rd_data_d = rd_data_q;
        rd_pkts_d = rd_pkts_q;
        if (rd_val_d) begin
            rd_data_d = s2_bytes_q;
            rd_pkts_d = s2_pkts_q;
        end
        mem_we    = !init_done_q || s2_we;
        mem_waddr = init_done_q ? s2_flow_q : init_addr_q;
        mem_wdata = init_done_q ? {s2_wp, s2_wb} : '0;
    end

    // Storage: synchronous write, registered read returning old data on collision.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        ram_q <= mem[s0_flow_q];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            init_done_q <= 1'b0;
            init_addr_q <= '0;
            pend_q      <= 1'b0;
            pend_flow_q <= '0;
            s0_vld_q    <= 1'b0;
            s0_rd_q     <= 1'b0;
            s0_flow_q   <= '0;
            s0_size_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_rd_q     <= 1'b0;
            s1_flow_q   <= '0;
            s1_size_q   <= '0;
            s2_vld_q    <= 1'b0;
            s2_rd_q     <= 1'b0;
            s2_flow_q   <= '0;
            s2_size_q   <= '0;
            s2_bytes_q  <= '0;
            s2_pkts_q   <= '0;
            lw_vld_q    <= 1'b0;
            lw_flow_q   <= '0;
            lw_bytes_q  <= '0;
            lw_pkts_q   <= '0;
            rd_data_q   <= '0;
            rd_pkts_q   <= '0;
            rd_val_q    <= 1'b0;
        end else begin
            init_done_q <= init_done_d;
            init_addr_q <= init_addr_d;
            pend_q      <= pend_d;
            pend_flow_q <= pend_flow_d;
            s0_vld_q    <= s0_vld_d;
            s0_rd_q     <= s0_rd_d;
            s0_flow_q   <= s0_flow_d;
            s0_size_q   <= s0_size_d;
            s1_vld_q    <= s0_vld_q;
            s1_rd_q     <= s0_rd_q;
            s1_flow_q   <= s0_flow_q;
            s1_size_q   <= s0_size_q;
            s2_vld_q    <= s1_vld_q;
            s2_rd_q     <= s1_rd_q;
            s2_flow_q   <= s1_flow_q;
            s2_size_q   <= s1_size_q;
            s2_bytes_q  <= s2_bytes_d;
            s2_pkts_q   <= s2_pkts_d;
            lw_vld_q    <= s2_we;
            lw_flow_q   <= s2_flow_q;
            lw_bytes_q  <= s2_wb;
            lw_pkts_q   <= s2_wp;
            rd_data_q   <= rd_data_d;
            rd_pkts_q   <= rd_pkts_d;
            rd_val_q    <= rd_val_d;
        end
    end
endmodule
